// File: rtl/adc_sample_sequencer.sv
// Sample-period scheduler: converts X then Y on one shared ADC and publishes each coherent pair.
// Optional build macro SAMPLE_SEQ_FRAME_CNT_EN adds frame_count and drop_count diagnostics.
`timescale 1ns/1ps
module adc_sample_sequencer #(
  parameter int DW      = 16,
  parameter int CLK_DIV = 1000,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          adc_start,
  output logic          adc_chan,
  input  logic          adc_done,
  input  logic [DW-1:0] adc_data,
  output logic [DW-1:0] xant_sample,
  output logic [DW-1:0] yant_sample,
  output logic          sample_strobe,
  output logic          osc_next,
  input  logic          err_clr,
  output logic          overrun,
  output logic          timeout_err
`ifdef SAMPLE_SEQ_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_count,
  output logic [7:0]    drop_count
`endif
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_X  = 2'd1;
  localparam logic [1:0] S_WAIT_Y  = 2'd2;
  localparam logic [1:0] S_PUBLISH = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] period_cnt;
  logic [WD_W-1:0]  wd_cnt;
  logic [DW-1:0]    x_hold;
  logic             tick;
  logic             done_ok;
  logic             waiting;
  logic             wd_expired;
  logic             tick_drop;

  // A done pulse coinciding with our own start request belongs to no conversion.
  assign tick       = en && (period_cnt == CNT_LAST);
  assign done_ok    = adc_done && !adc_start;
  assign waiting    = (state == S_WAIT_X) || (state == S_WAIT_Y);
  assign wd_expired = waiting && !done_ok && (wd_cnt == WD_LAST);
  assign tick_drop  = tick && (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      period_cnt <= '0;
    end else if (tick) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      wd_cnt        <= '0;
      x_hold        <= '0;
      adc_start     <= 1'b0;
      adc_chan      <= 1'b0;
      xant_sample   <= '0;
      yant_sample   <= '0;
      sample_strobe <= 1'b0;
      osc_next      <= 1'b0;
      overrun       <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      adc_start     <= 1'b0;
      adc_chan      <= 1'b0;
      sample_strobe <= 1'b0;
      osc_next      <= 1'b0;

      // Set conditions are written after the clear so they win in the same cycle.
      if (err_clr) begin
        overrun     <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (tick_drop) overrun <= 1'b1;
      if (wd_expired) timeout_err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (tick) begin
            adc_start <= 1'b1;
            wd_cnt    <= '0;
            state     <= S_WAIT_X;
          end
        end
        S_WAIT_X: begin
          if (done_ok) begin
            x_hold    <= adc_data;
            adc_start <= 1'b1;
            adc_chan  <= 1'b1;
            wd_cnt    <= '0;
            state     <= S_WAIT_Y;
          end else if (wd_expired) begin
            state <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        S_WAIT_Y: begin
          if (done_ok) begin
            xant_sample   <= x_hold;
            yant_sample   <= adc_data;
            sample_strobe <= 1'b1;
            osc_next      <= 1'b1;
            state         <= S_PUBLISH;
          end else if (wd_expired) begin
            state <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        S_PUBLISH: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

`ifdef SAMPLE_SEQ_FRAME_CNT_EN
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] n);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, n};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  logic       pub_now;
  logic [1:0] drop_events;
  logic [7:0] drop_base;

  // A dropped tick and a timeout can land in the same cycle; both are counted.
  assign pub_now     = (state == S_WAIT_Y) && done_ok;
  assign drop_events = {1'b0, tick_drop} + {1'b0, wd_expired};
  assign drop_base   = err_clr ? 8'h00 : drop_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      if (pub_now) frame_count <= frame_count + 16'd1;
      drop_count <= sat_add8(drop_base, drop_events);
    end
  end
`endif

endmodule

// File: doc/adc_sample_sequencer.md
Name: adc_sample_sequencer

Overview:
- Sample-rate scheduler for the antenna receive datapath.
- Divides `clk` into a fixed sample period and time-shares the single ADC between the X and Y antenna channels (X first, then Y).
- Publishes each coherent X/Y sample pair to both `signal_path` instances with a one-cycle `sample_strobe`.
- Pulses `osc_next` in the same cycle, so the I/Q oscillator advances once per published frame.

Parameters:
- DW, 16: ADC sample and output width.
- CLK_DIV, 1000: clk cycles per sample period. Minimum 8.
- TIMEOUT, 255: maximum clk cycles to wait for `adc_done` after `adc_start`. Minimum 2.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- en  in  1  sequencer enable.
- adc_start  out  1  one-cycle conversion request.
- adc_chan  out  1  channel select, valid while `adc_start`=1. 0 = X, 1 = Y.
- adc_done  in  1  one-cycle conversion-complete pulse from the ADC interface.
- adc_data  in  DW  conversion result, valid when `adc_done`=1.
- xant_sample  out  DW  published X sample.
- yant_sample  out  DW  published Y sample.
- sample_strobe  out  1  one-cycle pulse; new X/Y pair is valid this cycle.
- osc_next  out  1  one-cycle oscillator advance; identical timing to `sample_strobe`.
- err_clr  in  1  clears the sticky error flags.
- overrun  out  1  sticky: a period tick occurred while a frame was still in progress.
- timeout_err  out  1  sticky: the ADC failed to respond within TIMEOUT cycles.

Behaviour:
- Reset:
  - All outputs 0, state IDLE, period counter 0, watchdog 0, X holding register 0.
  - Reset mid-conversion aborts the conversion; any later `adc_done` is ignored while in IDLE.
- Period counter:
  - Counts 0..CLK_DIV-1 and wraps while `en`=1.
  - Held at 0 while `en`=0.
  - Internal tick occurs when count == CLK_DIV-1 and `en`=1.
- States: IDLE, WAIT_X, WAIT_Y, PUBLISH. All outputs are registered.
- IDLE:
  - On a tick at cycle T: at T+1, `adc_start`=1 and `adc_chan`=0; state becomes WAIT_X.
- WAIT_X:
  - `adc_done` is ignored in any cycle where `adc_start`=1.
  - On `adc_done` at cycle D: latch `adc_data` into the X holding register.
  - At D+1: `adc_start`=1, `adc_chan`=1; state becomes WAIT_Y.
- WAIT_Y:
  - On `adc_done` at cycle E: at E+1, `xant_sample` ← holding register, `yant_sample` ← `adc_data`.
  - At E+1, `sample_strobe`=1 and `osc_next`=1; state PUBLISH for that one cycle, then IDLE.
  - Both output samples change only in strobe cycles.
- Latency: tick-to-strobe = 2 + X ADC latency + 1 + Y ADC latency.
- Watchdog:
  - Reloads on every `adc_start`.
  - After TIMEOUT cycles in WAIT_X/WAIT_Y without `adc_done`: `timeout_err` ← 1, state ← IDLE.
  - On timeout: no strobe, no `osc_next`, published samples hold.
- Overrun:
  - A tick while state ≠ IDLE sets `overrun`; that tick is dropped.
  - The in-progress frame continues and publishes normally.
  - The next frame starts at the next tick that finds IDLE.
- Tick and return-to-IDLE in the same cycle: the tick counts as an overrun and is dropped.
- Sticky flags:
  - `err_clr` clears both flags the next cycle.
  - A set condition in the same cycle as `err_clr` wins; the flag stays 1.
- `en` deasserted mid-frame: the in-flight frame completes and publishes; no new `adc_start` is issued.
- Stray `adc_done` in IDLE or PUBLISH: ignored.

Optional Feature:
- Macro: SAMPLE_SEQ_FRAME_CNT_EN.
- Defined:
  - Adds output port `frame_count` [15:0]. Reset 0.
  - Increments (wrapping at 0xFFFF→0) in the same cycle `sample_strobe` is asserted; the new value is visible alongside the strobe.
  - Adds output port `drop_count` [7:0]. Reset 0. Saturates at 0xFF.
  - `drop_count` increments on every dropped tick (overrun) and every timeout.
  - `err_clr` zeroes `drop_count`.
- Undefined: neither port exists and no counter logic is synthesised.
- All other behaviour is identical in both builds.

Test Plan:
- Bench settings: CLK_DIV=20, TIMEOUT=10, DW=16.
- ADC model: `adc_done` 3 cycles after `adc_start`; data 0x1234 (X), 0xABCD (Y).
- Cases:
  - Normal frames: `en` rises at cycle 0 → first `adc_start` at cycle 20 (`adc_chan`=0), second at 24 (`adc_chan`=1); `sample_strobe`/`osc_next` at 28 with `xant_sample`=0x1234, `yant_sample`=0xABCD; repeats every 20 cycles; errors stay 0.
  - Y never completes: `timeout_err`=1 ten cycles after the Y `adc_start`; no strobe; outputs hold the previous frame; the next tick resumes normal frames.
  - ADC latency 12 cycles per channel (frame exceeds 20 cycles): `overrun`=1 at the tick during WAIT_Y; that frame still publishes; strobes occur at most every other period.
  - Overrun tick in the same cycle as `err_clr`=1 → `overrun` remains 1; `err_clr` alone the next cycle → 0.
  - Mid-frame events:
    - Drop `en` during WAIT_X → the frame completes and strobes once; no further `adc_start`.
    - Assert `rst` during WAIT_Y → all outputs 0 next cycle; subsequent `adc_done` is ignored.
  - With SAMPLE_SEQ_FRAME_CNT_EN: after 3 normal frames `frame_count`=3; one timeout plus one overrun → `drop_count`=2; `err_clr` → `drop_count`=0.
